// File: rtl/shift_seq_ctrl.sv
// Round-robin word sequencer for a right-shift serial datapath: grants one of two
// requesters, then shifts the accepted word out LSB-first with done/idle-gap framing.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_data_i,
  output logic             req1_ready_o,
  output logic             ser_out_o,
  output logic             ser_en_o,
  output logic             grant_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             ptr_q, ptr_d;
  logic             grant_q, grant_d;
  logic             win1;

  // Requester 1 wins when it is the only one valid, or when both are valid and 0 was served last.
  assign win1 = req1_valid_i && (!req0_valid_i || !ptr_q);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bcnt_d       = bcnt_q;
    gcnt_d       = gcnt_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    ser_en_o     = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready_o = req0_valid_i && !win1;
        req1_ready_o = win1;
        if (req0_valid_i || req1_valid_i) begin
          shreg_d = win1 ? req1_data_i : req0_data_i;
          bcnt_d  = BW'(WIDTH - 1);
          ptr_d   = win1;
          grant_d = win1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_en_o = 1'b1;
        shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
        bcnt_d   = bcnt_q - 1'b1;
        if (bcnt_q == '0) begin
          done_o = 1'b1;
          bcnt_d = '0;
          if (GAP > 0) begin
            gcnt_d  = GW'(GAP - 1);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q - 1'b1;
        if (gcnt_q == '0) begin
          gcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      ptr_q   <= 1'b1;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign ser_out_o = ser_en_o & shreg_q[0];
  assign busy_o    = (state_q != S_IDLE);
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: three instances (GAP=1, 0, 3), one active at a time;
// expected bits are queued at each handshake and popped whenever ser_en is high.
module tb_shift_seq_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] v0, v1, rdy0, rdy1, so, se, gr, bz, dn;
  logic [W-1:0] d0 [3];
  logic [W-1:0] d1 [3];

  always #5 clk = ~clk;

  function automatic int gap_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    shift_seq_ctrl #(.WIDTH(W), .GAP(gap_of(k))) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req0_valid_i (v0[k]),
      .req0_data_i  (d0[k]),
      .req0_ready_o (rdy0[k]),
      .req1_valid_i (v1[k]),
      .req1_data_i  (d1[k]),
      .req1_ready_o (rdy1[k]),
      .ser_out_o    (so[k]),
      .ser_en_o     (se[k]),
      .grant_o      (gr[k]),
      .busy_o       (bz[k]),
      .done_o       (dn[k])
    );
  end

  typedef struct packed {
    logic b;
    logic last;
    logic g;
    logic b2b;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int n_chk = 0;
  int n_err = 0;
  int low_run = 0;
  int bcnt = 0;
  logic [1:0] cur = 2'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: every bit-valid cycle must match the next queued bit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bz[cur]) bcnt++;
      if (se[cur]) begin
        if (sb.size() == 0) begin
          chk("extra_bit", 32'(se[cur]), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ser_out", 32'(so[cur]), 32'(e.b));
          chk("done", 32'(dn[cur]), 32'(e.last));
          chk("grant", 32'(gr[cur]), 32'(e.g));
          chk("busy_shift", 32'(bz[cur]), 32'd1);
          if (e.b2b) chk("gap_len", low_run, gap_of(32'(cur)) + 1);
        end
        low_run = 0;
      end else begin
        low_run++;
        chk("done_idle", 32'(dn[cur]), 32'd0);
        chk("ser_out_idle", 32'(so[cur]), 32'd0);
      end
    end
  end

  task automatic do_reset();
    v0 = '0;
    v1 = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_rdy0", 32'(rdy0[cur]), 32'd0);
    chk("rst_rdy1", 32'(rdy1[cur]), 32'd0);
    chk("rst_ser_out", 32'(so[cur]), 32'd0);
    chk("rst_ser_en", 32'(se[cur]), 32'd0);
    chk("rst_busy", 32'(bz[cur]), 32'd0);
    chk("rst_done", 32'(dn[cur]), 32'd0);
    chk("rst_grant", 32'(gr[cur]), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Called at posedge+1 of the cycle in which the handshake is due.
  task automatic hs(input int idx, input logic [W-1:0] d, input logic b2b);
    ent_t x;
    @(negedge clk);
    chk("hs_rdy0", 32'(rdy0[cur]), 32'(idx == 0));
    chk("hs_rdy1", 32'(rdy1[cur]), 32'(idx == 1));
    for (int i = 0; i < W; i++) begin
      x.b    = d[i];
      x.last = (i == W - 1);
      x.g    = idx[0];
      x.b2b  = b2b && (i == 0);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("busy_rdy0", 32'(rdy0[cur]), 32'd0);
      chk("busy_rdy1", 32'(rdy1[cur]), 32'd0);
      chk("busy", 32'(bz[cur]), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    v0 = '0;
    v1 = '0;
    for (int k = 0; k < 3; k++) begin
      d0[k] = '0;
      d1[k] = '0;
    end
    #2;
    do_reset();

    // Single req0 word 1011
    v0[0] = 1'b1;
    d0[0] = 4'b1011;
    bcnt = 0;
    hs(0, 4'b1011, 1'b0);
    v0[0] = 1'b0;
    d0[0] = '0;
    wait_busy(5);
    @(negedge clk);
    #1;
    chk("busy_cycles", bcnt, 5);
    chk("t1_idle_busy", 32'(bz[0]), 32'd0);
    chk("t1_grant_hold", 32'(gr[0]), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Both valid: alternate 0,1,0,1
    do_reset();
    v0[0] = 1'b1;
    v1[0] = 1'b1;
    d0[0] = 4'hA;
    d1[0] = 4'h5;
    hs(0, 4'hA, 1'b0);
    wait_busy(5);
    hs(1, 4'h5, 1'b1);
    wait_busy(5);
    hs(0, 4'hA, 1'b1);
    wait_busy(5);
    hs(1, 4'h5, 1'b1);
    v0[0] = 1'b0;
    v1[0] = 1'b0;
    wait_busy(5);
    drain();
    @(negedge clk);
    chk("t2_grant_hold", 32'(gr[0]), 32'd1);
    @(posedge clk);
    #1;

    // Only req1, three words back-to-back; data changes after each handshake
    do_reset();
    v1[0] = 1'b1;
    d1[0] = 4'h3;
    hs(1, 4'h3, 1'b0);
    d1[0] = 4'hC;
    wait_busy(5);
    hs(1, 4'hC, 1'b1);
    d1[0] = 4'h9;
    wait_busy(5);
    hs(1, 4'h9, 1'b1);
    v1[0] = 1'b0;
    wait_busy(5);
    drain();

    // Reset after two bits of a word
    v0[0] = 1'b1;
    d0[0] = 4'b1001;
    hs(0, 4'b1001, 1'b0);
    v0[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ser_en", 32'(se[0]), 32'd0);
    chk("mid_rst_ser_out", 32'(so[0]), 32'd0);
    chk("mid_rst_busy", 32'(bz[0]), 32'd0);
    chk("mid_rst_done", 32'(dn[0]), 32'd0);
    chk("mid_rst_grant", 32'(gr[0]), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0[0] = 1'b1;
    v1[0] = 1'b1;
    d0[0] = 4'b0110;
    d1[0] = 4'hF;
    hs(0, 4'b0110, 1'b0);
    v0[0] = 1'b0;
    v1[0] = 1'b0;
    wait_busy(5);
    drain();

    // GAP=0 and GAP=3 instances, continuous req0
    for (int k = 1; k < 3; k++) begin
      cur = 2'(k);
      v0[k] = 1'b1;
      d0[k] = 4'h3;
      hs(0, 4'h3, 1'b0);
      d0[k] = 4'hC;
      wait_busy(W + gap_of(k));
      hs(0, 4'hC, 1'b1);
      d0[k] = 4'h6;
      wait_busy(W + gap_of(k));
      hs(0, 4'h6, 1'b1);
      v0[k] = 1'b0;
      wait_busy(W + gap_of(k));
      drain();
    end

    // req0 pulsed for one cycle mid-word: must not be accepted
    cur = 2'd0;
    v0[0] = 1'b1;
    d0[0] = 4'hC;
    hs(0, 4'hC, 1'b0);
    v0[0] = 1'b0;
    wait_busy(1);
    v0[0] = 1'b1;
    d0[0] = 4'hF;
    wait_busy(1);
    v0[0] = 1'b0;
    wait_busy(3);
    repeat (8) begin
      @(negedge clk);
      chk("pulse_rdy0", 32'(rdy0[0]), 32'd0);
      chk("pulse_ser_en", 32'(se[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the right-shift serial datapath: arbitrates round-robin between two requesters offering parallel words, loads the winning word, and shifts it out LSB-first, one bit per clock. It frames each word with a bit-valid strobe, a done pulse and a configurable idle gap. It sits between word-level producers and any serial sink that consumes a shift-register bit stream.

## Interface
- WIDTH, default 4: word length in bits; WIDTH ≥ 2.
- GAP, default 1: extra idle cycles after each word before the next grant; GAP ≥ 0.

- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- req0_valid  input  1  requester 0 offers a word.
- req0_data  input  WIDTH  requester 0 word; sampled only on handshake edge.
- req0_ready  output  1  controller accepts req0 this cycle.
- req1_valid  input  1  requester 1 offers a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  controller accepts req1 this cycle.
- ser_out  output  1  current serial bit; 0 when ser_en is low.
- ser_en  output  1  ser_out carries a valid bit.
- grant  output  1  index of requester being served; holds the last served index when idle.
- busy  output  1  high in SHIFT and GAP states.
- done  output  1  one-cycle pulse coincident with the last bit of a word.

## Operation
- Reset values: state IDLE, shift register 0, bit counter 0, gap counter 0, last-served pointer 1. All outputs 0: ready, ser_out, ser_en, busy, done and grant.
- FSM states: IDLE, SHIFT, GAP.
- IDLE
  - Winner is the valid requester.
  - If both are valid, the winner is the requester not equal to the last-served pointer; req0 wins first after reset.
  - reqN_ready = (state==IDLE) && (winner==N). Ready is combinational from valid and the pointer; at most one ready is high.
- Handshake on valid && ready at a rising edge:
  - load shift register with reqN_data;
  - bit counter ← WIDTH-1;
  - grant and last-served pointer ← N;
  - state ← SHIFT.
- SHIFT
  - ser_en=1, ser_out=shreg[0].
  - Each edge: shreg ← {1'b0, shreg[WIDTH-1:1]} and the counter decrements.
  - When the counter is 0: done=1 that cycle. Next state is GAP with gap counter ← GAP-1 if GAP>0, else IDLE.
- GAP: ser_en=0, ready=0. Decrement each cycle; at 0 → IDLE.
- Valid deasserted before a handshake has no effect; no request is latched. Data is not required to be held after the handshake edge.
- A requester whose valid stays high while the other is served keeps priority for the next grant, so neither requester can starve.
- Reset asserted mid-word: the word is dropped, no done pulse is issued, all outputs go to reset values asynchronously, and the pointer returns to 1.

## Timing
- Handshake edge at cycle t: bits b0..b(WIDTH-1) appear on ser_out in cycles t+1..t+WIDTH, and done is high in cycle t+WIDTH.
- After the last bit: GAP cycles in GAP, then ≥1 cycle in IDLE, which is the earliest handshake.
- Minimum word period = WIDTH + GAP + 1 cycles.
- ser_en is low for exactly GAP+1 cycles between back-to-back words.
- busy rises the cycle after the handshake and falls on entry to IDLE.
- grant updates on the handshake edge.
- ready never asserts in SHIFT or GAP.

## Test plan
- WIDTH=4, GAP=1, only req0_valid with data 4'b1011:
  - req0_ready high in the first IDLE cycle after reset release;
  - ser_out = 1,1,0,1 with ser_en high for 4 cycles;
  - done on the 4th bit, busy for 5 cycles.
- Both valid continuously (req0=4'hA, req1=4'h5) after reset:
  - served order is req0, req1, req0, req1 with grant alternating;
  - each word's bits are correct and the gap between words is 2 ser_en-low cycles.
- Only req1_valid held high for three words:
  - all three are accepted back-to-back at period 6 (WIDTH=4, GAP=1);
  - the pointer does not block the repeat grant.
- Reset asserted after 2 bits of a word:
  - all outputs go to 0 immediately, with no done pulse;
  - after release a new req0 word 4'b0110 shifts out 0,1,1,0 from the start.
- GAP=0 vs GAP=3 with a continuous req0: ser_en-low runs between words are 1 and 4 cycles respectively.
- req0_valid pulsed for one cycle during SHIFT and dropped before IDLE: no handshake, no extra word, ready stays 0.
